// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one handshaked memory transaction per instruction between EXU and WBU.
// Store data is lane-replicated with byte strobes; load data is lane-extracted and extended.
module ysyx_25020047_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic        in_reg_wen,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_reg_wen,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;

  logic        accept;
  logic        is_mem;
  logic        bad;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign accept        = (state == IDLE) && in_valid;
  assign is_mem        = in_read | in_write;
  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);
  assign out_err       = err_q & (state == DONE);

  // Faults are only meaningful for memory ops; they short-circuit straight to DONE.
  always_comb begin
    bad = (in_read & in_write) | (in_size == 2'b11) |
          ((in_size == 2'b10) && (in_result[1:0] != 2'b00)) |
          ((in_size == 2'b01) && in_result[0]);
  end

  always_comb begin
    st_wdata = in_wdata;
    st_wmask = 4'hF;
    case (in_size)
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wmask = 4'b0001 << in_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wmask = 4'b0011 << in_result[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_lane = mem_rsp_rdata[7:0];
      2'd1:    byte_lane = mem_rsp_rdata[15:8];
      2'd2:    byte_lane = mem_rsp_rdata[23:16];
      default: byte_lane = mem_rsp_rdata[31:24];
    endcase
    half_lane = lane_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_data = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)      next_state = (!is_mem || bad) ? DONE : REQ;
      REQ:  if (mem_req_ready) next_state = mem_req_wen ? DONE : WAIT;
      WAIT: if (mem_rsp_valid) next_state = DONE;
      DONE: if (out_ready)     next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Request fields are registered at accept so they stay stable under req backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q        <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      err_q         <= 1'b0;
      out_data      <= 32'h0;
      out_reg_wen   <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= 32'h0;
      mem_req_wmask <= 4'h0;
    end else begin
      if (accept) begin
        lane_q      <= in_result[1:0];
        size_q      <= in_size;
        uns_q       <= in_unsigned;
        err_q       <= is_mem & bad;
        out_reg_wen <= in_reg_wen & ~(is_mem & bad);
        out_data    <= in_result;
        if (is_mem && !bad) begin
          mem_req_addr  <= {in_result[31:2], 2'b00};
          mem_req_wen   <= in_write;
          mem_req_wdata <= in_write ? st_wdata : 32'h0;
          mem_req_wmask <= in_write ? st_wmask : 4'h0;
        end
      end
      if ((state == WAIT) && mem_rsp_valid) out_data <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for ysyx_25020047_lsu: a byte-level reference model predicts requests and
// results; a memory responder and an output monitor check them as the DUT presents them.
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_wdata;
  logic        in_reg_wen, in_read, in_write, in_unsigned;
  logic [1:0]  in_size;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid, out_ready, out_reg_wen, out_err;
  logic [31:0] out_data;

  ysyx_25020047_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_reg_wen(in_reg_wen), .in_read(in_read), .in_write(in_write), .in_size(in_size),
    .in_unsigned(in_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_reg_wen(out_reg_wen), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        reg_wen;
    logic        err;
    int          lat;
    int          acc;
  } out_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          req_delay;
    int          rsp_delay;
  } req_exp_t;

  out_exp_t    out_q[$];
  req_exp_t    req_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  ref_mem [64];
  logic [31:0] mem_words [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s got=event exp=none (t=%0t)", name, $time);
  endtask

  task automatic pokeWord(input int idx, input logic [31:0] val);
    mem_words[idx] = val;
    for (int i = 0; i < 4; i++) ref_mem[4*idx+i] = val[8*i +: 8];
  endtask

  // Reference model: the access is a run of nbytes bytes starting at the byte address.
  task automatic applyStimulus(input logic [31:0] result, input logic [31:0] wdata,
                               input logic reg_wen, input logic rd, input logic wr,
                               input logic [1:0] size, input logic uns,
                               input int req_d, input int rsp_d);
    out_exp_t    e;
    req_exp_t    r;
    int          nbytes, off, wait_cnt;
    logic        mem_op, bad;
    logic [31:0] val;
    nbytes = 1 << size;
    off    = int'(result - 32'h80000000);
    mem_op = rd | wr;
    bad    = mem_op && ((rd && wr) || (size == 2'd3) || ((off % nbytes) != 0));
    e.data    = result;
    e.reg_wen = reg_wen & ~bad;
    e.err     = bad;
    e.lat     = (!mem_op || bad) ? 1 : (wr ? 2 + req_d : 3 + req_d + rsp_d);
    e.acc     = 0;
    r.addr      = {result[31:2], 2'b00};
    r.wen       = wr;
    r.wdata     = 32'h0;
    r.wmask     = 4'h0;
    r.req_delay = req_d;
    r.rsp_delay = rsp_d;
    if (mem_op && !bad) begin
      if (wr) begin
        for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = wdata[8*(j % nbytes) +: 8];
        for (int i = 0; i < nbytes; i++) begin
          r.wmask[(off % 4) + i] = 1'b1;
          ref_mem[off+i] = wdata[8*i +: 8];
        end
      end else begin
        val = 32'h0;
        for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[off+i];
        if (!uns && nbytes < 4)
          for (int k = 8*nbytes; k < 32; k++) val[k] = val[8*nbytes-1];
        e.data = val;
      end
    end
    @(negedge clk);
    in_valid    = 1'b1;
    in_result   = result;
    in_wdata    = wdata;
    in_reg_wen  = reg_wen;
    in_read     = rd;
    in_write    = wr;
    in_size     = size;
    in_unsigned = uns;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) begin
      flagFail("accept_timeout");
      in_valid = 1'b0;
    end else begin
      e.acc = cyc;
      out_q.push_back(e);
      if (mem_op && !bad) req_q.push_back(r);
      @(negedge clk);
      in_valid    = 1'b0;
      in_result   = $urandom;
      in_wdata    = $urandom;
      in_read     = 1'($urandom);
      in_write    = 1'($urandom);
      in_size     = 2'($urandom);
      in_unsigned = 1'($urandom);
      in_reg_wen  = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (out_q.size() != 0 || req_q.size() != 0) flagFail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    checkOutput({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'h0);
    checkOutput({tag, "_mem_req_wen"}, 32'(mem_req_wen), 32'h0);
    checkOutput({tag, "_mem_req_addr"}, mem_req_addr, 32'h0);
    checkOutput({tag, "_mem_req_wdata"}, mem_req_wdata, 32'h0);
    checkOutput({tag, "_mem_req_wmask"}, 32'(mem_req_wmask), 32'h0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, "_out_data"}, out_data, 32'h0);
    checkOutput({tag, "_out_reg_wen"}, 32'(out_reg_wen), 32'h0);
    checkOutput({tag, "_out_err"}, 32'(out_err), 32'h0);
  endtask

  // Memory responder: checks each request against the model, holds ready low for the
  // requested delay, applies stores by strobe and returns loads after the response delay.
  initial begin
    logic        drove, active, pend, cap_wen;
    int          rcnt, wcnt;
    logic [31:0] pdata, cap_addr, cap_wdata;
    logic [3:0]  cap_wmask;
    req_exp_t    cur;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    drove = 1'b0; active = 1'b0; pend = 1'b0; cap_wen = 1'b0;
    rcnt = 0; wcnt = 0; pdata = 32'h0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_wmask = 4'h0;
    cur.wen = 1'b0; cur.req_delay = 0; cur.rsp_delay = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        drove = 1'b0;
        active = 1'b0;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
        if (drove) begin
          drove = 1'b0;
          mem_req_ready = 1'b0;
          if (cap_wen) begin
            for (int j = 0; j < 4; j++)
              if (cap_wmask[j]) mem_words[cap_addr[5:2]][8*j +: 8] = cap_wdata[8*j +: 8];
          end else begin
            pend  = 1'b1;
            wcnt  = cur.rsp_delay;
            pdata = mem_words[cap_addr[5:2]];
          end
        end
        if (pend) begin
          if (wcnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pdata;
            pend = 1'b0;
          end else begin
            wcnt--;
          end
        end
        if (mem_req_valid) begin
          if (!active) begin
            active = 1'b1;
            if (req_q.size() == 0) begin
              flagFail("unexpected_mem_req");
              cur.wen = mem_req_wen; cur.req_delay = 0; cur.rsp_delay = 0;
            end else begin
              cur = req_q.pop_front();
              checkOutput("req_addr", mem_req_addr, cur.addr);
              checkOutput("req_wen", 32'(mem_req_wen), 32'(cur.wen));
              checkOutput("req_wmask", 32'(mem_req_wmask), 32'(cur.wmask));
              if (cur.wen) checkOutput("req_wdata", mem_req_wdata, cur.wdata);
            end
            cap_addr = mem_req_addr; cap_wen = mem_req_wen;
            cap_wdata = mem_req_wdata; cap_wmask = mem_req_wmask;
            rcnt = cur.req_delay;
          end else begin
            checkOutput("req_hold_addr", mem_req_addr, cap_addr);
            checkOutput("req_hold_wdata", mem_req_wdata, cap_wdata);
            checkOutput("req_hold_wmask", 32'(mem_req_wmask), 32'(cap_wmask));
            checkOutput("req_hold_wen", 32'(mem_req_wen), 32'(cap_wen));
          end
          if (rcnt == 0) begin
            mem_req_ready = 1'b1;
            drove = 1'b1;
            active = 1'b0;
          end else begin
            rcnt--;
          end
        end
      end
    end
  end

  // Output monitor: pops an expectation the first time out_valid is seen, then checks the
  // outputs stay frozen while the WBU side randomly withholds out_ready.
  initial begin
    logic        holding, snap_w, snap_e;
    logic [31:0] snap_d;
    out_exp_t    e;
    holding = 1'b0; snap_w = 1'b0; snap_e = 1'b0; snap_d = 32'h0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!holding) begin
          if (out_q.size() == 0) begin
            flagFail("unexpected_out_valid");
          end else begin
            e = out_q.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_reg_wen", 32'(out_reg_wen), 32'(e.reg_wen));
            checkOutput("out_err", 32'(out_err), 32'(e.err));
            checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          holding = 1'b1;
          snap_d = out_data; snap_w = out_reg_wen; snap_e = out_err;
        end else begin
          checkOutput("out_hold_data", out_data, snap_d);
          checkOutput("out_hold_reg_wen", 32'(out_reg_wen), 32'(snap_w));
          checkOutput("out_hold_err", 32'(out_err), 32'(snap_e));
        end
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_ready) holding = 1'b0;
      end else begin
        out_ready = 1'($urandom);
        holding = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=stuck exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          kind, off;
    logic        rd, wr;
    logic [1:0]  sz;
    in_valid = 1'b0; in_result = 32'h0; in_wdata = 32'h0; in_reg_wen = 1'b0;
    in_read = 1'b0; in_write = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
    for (int i = 0; i < 16; i++) pokeWord(i, $urandom);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    #2 rst_n = 1'b1;

    pokeWord(1, 32'hDEADBEEF);
    pokeWord(0, 32'h81223344);
    applyStimulus(32'h00001234, 32'h0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 0);
    applyStimulus(32'h80000004, 32'h0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 2);
    applyStimulus(32'h80000003, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 0, 0);
    applyStimulus(32'h80000003, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1, 0);
    applyStimulus(32'h80000002, 32'h000000A5, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3, 0);
    applyStimulus(32'h80000006, 32'h12345678, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0);
    applyStimulus(32'h80000002, 32'h0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 0, 1);
    drain();

    // Reset while the load sits in WAIT; its late response must be ignored.
    applyStimulus(32'h80000008, 32'h0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 6);
    repeat (2) @(negedge clk);
    checkOutput("wait_in_ready", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    void'(out_q.pop_back());
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("post_stray_in_ready", 32'(in_ready), 32'h1);
    checkOutput("post_stray_out_valid", 32'(out_valid), 32'h0);
    applyStimulus(32'h80000008, 32'h0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1, 1);
    drain();

    $display("[TB] starting randomized phase");
    repeat (250) begin
      kind = $urandom_range(0, 19);
      rd = (kind < 8) || (kind == 19);
      wr = ((kind >= 8) && (kind < 16)) || (kind == 19);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = $urandom_range(0, 63);
      if (($urandom_range(0, 3) != 0) && (sz != 2'd3)) off = off & ~((1 << sz) - 1);
      applyStimulus(32'h80000000 + 32'(off), $urandom, 1'($urandom), rd, wr, sz,
                    1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
# ysyx_25020047_lsu

Load/store unit that sits directly downstream of the execute unit in the NPC core. It takes the EXU's computed result (effective address or ALU value), store data, register write-enable and read/write strobes, and performs at most one memory transaction per instruction over a valid/ready request/response bus. It forwards the load data, or the passed-through ALU result, to write-back. It replaces the combinational memory access with a multi-cycle, handshaked stage.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EXU has an instruction for this stage
- in_ready  out  1  stage can accept; high only in IDLE
- in_result  in  32  EXU result (address for load/store)
- in_wdata  in  32  store data (rs2)
- in_reg_wen  in  1  instruction writes rd
- in_read  in  1  load
- in_write  in  1  store
- in_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- in_unsigned  in  1  zero-extend load (lbu/lhu)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wen  out  1  1 = store, 0 = load
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wmask  out  4  byte-lane strobes; 0 for loads
- mem_rsp_valid  in  1  response valid; always accepted in WAIT
- mem_rsp_rdata  in  32  aligned word read data
- out_valid  out  1  result valid toward WBU
- out_ready  in  1  WBU accepts
- out_data  out  32  load data or passed-through in_result
- out_reg_wen  out  1  write rd
- out_err  out  1  misaligned/illegal access; no memory traffic occurred

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, latch all in_* fields.
  - If neither read nor write is set, go to DONE, with out_data=in_result.
  - If both read and write are set, in_size=11, word with addr[1:0]!=0, or half with addr[0]!=0, go to DONE with err=1.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, with addr, wen, wdata and wmask stable until mem_req_ready. On ready, a store goes to DONE and a load goes to WAIT.
- WAIT: on mem_rsp_valid, capture extracted data and go to DONE. mem_rsp_valid in any other state is ignored.
- DONE: out_valid=1, with all out_* held stable. On out_ready, go to IDLE.
- Store lanes:
  - byte: wdata={4{wdata[7:0]}}, wmask=4'b0001<<addr[1:0].
  - half: wdata={2{wdata[15:0]}}, wmask=4'b0011<<addr[1:0].
  - word: wdata unchanged, wmask=4'hF.
- Load extract:
  - byte lane = rdata[8*addr[1:0] +: 8].
  - half lane = rdata[16*addr[1] +: 16].
  - Sign-extend unless in_unsigned. Word loads are returned unchanged.
- out_reg_wen = latched reg_wen & ~err. Stores carry reg_wen=0 from EXU and it is passed through as is.
- out_err=1 only with out_valid. When out_err=1, out_data=latched in_result (faulting address).

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, out_valid=0, out_data=0, out_reg_wen=0, out_err=0.
- Accept at cycle T. A non-memory or error instruction has out_valid at T+1.
- Load with zero-wait memory: req at T+1, rsp at T+2, out_valid at T+3.
- Store with zero-wait memory: req at T+1, out_valid at T+2.
- Backpressure on either side holds the current state indefinitely, with no output changes.
- One instruction is in flight. No new accept until DONE has handshaken (in_ready is low in REQ, WAIT and DONE).
- Reset mid-transaction aborts to IDLE. The memory is reset with the same rst_n, so no stale response is expected. Any stray response is ignored.

## Test plan
- addi passthrough: in_result=0x1234, read=write=0, reg_wen=1 -> out_valid at T+1, out_data=0x1234, out_reg_wen=1, no mem_req_valid.
- lw at 0x80000004, mem returns 0xDEADBEEF after 2 wait cycles -> mem_req_addr=0x80000004, out_data=0xDEADBEEF, out_valid at T+5.
- lbu at 0x80000003 with rdata=0x81223344 -> 0x00000081. Same access with in_unsigned=0 (lb) -> 0xFFFFFF81.
- sb at 0x80000002, wdata=0x000000A5, mem_req_ready low for 3 cycles -> req fields held, wdata=0xA5A5A5A5, wmask=0100, wen=1, out_reg_wen=0.
- sw at 0x80000006 -> no mem_req_valid, out_err=1, out_data=0x80000006, out_reg_wen=0.
- rst_n deasserted while in WAIT, followed by a late mem_rsp_valid after release -> IDLE, all outputs at reset values, response ignored, next instruction is processed normally.
